// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce arbiter: FSM state encoding and
// the stable-time counter bound derived from clock frequency.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Cycles a level must stay stable; 64-bit so large ClkFreq*StableTime cannot overflow.
  function automatic longint unsigned counter_max(input longint unsigned clk_freq,
                                                  input longint unsigned stable_time);
    return (clk_freq * stable_time) / 64'd1_000_000;
  endfunction

endpackage

// File: rtl/sync_3ff.sv
// Three-flop synchronizer for a bus of independent asynchronous bits.
module sync_3ff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] sync_p0;
  logic [Width-1:0] sync_p1;
  logic [Width-1:0] sync_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      sync_p2 <= '0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign q = sync_p2;

endmodule

// File: rtl/debounce_arbiter.sv
// Multi-channel switch debouncer sharing one stable-time counter between
// channels, handed out round-robin to any channel whose input disagrees with its level.
module debounce_arbiter
  import debounce_pkg::*;
#(
  parameter int unsigned ClkFreq    = 100_000_000,
  parameter int unsigned StableTime = 10,
  parameter int unsigned NumSw      = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumSw-1:0]         sw_i,
  output logic [NumSw-1:0]         db_level_o,
  output logic [NumSw-1:0]         db_tick_o,
  output logic                     busy_o,
  output logic [$clog2(NumSw)-1:0] grant_o
);

  localparam longint unsigned CounterMax = counter_max(64'(ClkFreq), 64'(StableTime));
  localparam int unsigned     CntW       = $clog2(CounterMax + 1);
  localparam int unsigned     GrW        = $clog2(NumSw);
  localparam logic [CntW-1:0] CntLast    = CntW'(CounterMax - 1);

  logic [NumSw-1:0] sync;
  logic [NumSw-1:0] req;
  logic [NumSw-1:0] level, level_n;
  logic [NumSw-1:0] tick, tick_n;
  logic [CntW-1:0]  cnt, cnt_n;
  logic [GrW-1:0]   grant, grant_n;
  logic [GrW-1:0]   last_grant, last_n;
  logic [GrW-1:0]   pick;
  state_t           state, state_n;

  sync_3ff #(
    .Width(NumSw)
  ) u_sync (
    .clk(clk_i),
    .rst(rst_i),
    .d  (sw_i),
    .q  (sync)
  );

  assign req = sync ^ level;

  // Round-robin search starting just after the channel that last committed.
  always_comb begin
    pick = '0;
    for (int k = NumSw; k >= 1; k--) begin
      int idx;
      idx = (int'(last_grant) + k) % int'(NumSw);
      if (req[idx]) pick = GrW'(idx);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      grant      <= '0;
      last_grant <= GrW'(NumSw - 1);
      level      <= '0;
      tick       <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      grant      <= grant_n;
      last_grant <= last_n;
      level      <= level_n;
      tick       <= tick_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    grant_n = grant;
    last_n  = last_grant;
    level_n = level;
    tick_n  = '0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          grant_n = pick;
          cnt_n   = '0;
          state_n = COUNT;
        end
      end
      COUNT: begin
        // A bounce back to the current level abandons the timer without touching last_grant.
        if (sync[grant] == level[grant]) begin
          state_n = IDLE;
        end else if (cnt == CntLast) begin
          level_n[grant] = ~level[grant];
          tick_n[grant]  = ~level[grant];
          state_n        = COMMIT;
        end else begin
          cnt_n = cnt + CntW'(1);
        end
      end
      COMMIT: begin
        last_n  = grant;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy_o     = (state != IDLE);
  assign grant_o    = grant;
  assign db_level_o = level;
  assign db_tick_o  = tick;

endmodule

// File: doc/debounce_arbiter.md
DEBOUNCE_ARBITER -- requirements
Module: debounce_arbiter

Interface
REQ-001 Parameter ClkFreq, default 100_000_000, clock frequency in Hz.
REQ-002 Parameter StableTime, default 10, required stable time in microseconds.
REQ-003 Parameter NumSw, default 4, number of switch channels (2..16).
REQ-004 clk_i  input  1  single clock; all logic on rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 sw_i  input  NumSw  raw asynchronous switch inputs.
REQ-007 db_level_o  output  NumSw  debounced level per channel.
REQ-008 db_tick_o  output  NumSw  one-cycle pulse on debounced rising edge per channel.
REQ-009 busy_o  output  1  shared timer owned by a channel.
REQ-010 grant_o  output  $clog2(NumSw)  index of the channel owning the timer; valid when busy_o=1.

Function
REQ-011 CounterMax = ClkFreq*StableTime/1_000_000, computed in 64-bit arithmetic; counter width $clog2(CounterMax+1).
REQ-012 Each sw_i bit passes a 3-flop synchronizer; sync[n] = sw_i[n] after the 3rd flop.
REQ-013 Channel n requests when sync[n] != db_level_o[n].
REQ-014 One shared timer; FSM states IDLE, COUNT, COMMIT.
REQ-015 IDLE: no request -> stay IDLE; any request -> grant lowest requesting index at or after (last_grant+1) mod NumSw, clear counter, go COUNT.
REQ-016 COUNT: sync[grant] == db_level_o[grant] (bounce back) -> abort, go IDLE, no output change, last_grant unchanged.
REQ-017 COUNT: otherwise counter increments; when counter == CounterMax-1 go COMMIT.
REQ-018 On COUNT->COMMIT edge: db_level_o[grant] toggles; db_tick_o[grant] = 1 only if the new level is 1.
REQ-019 COMMIT: lasts one cycle; db_tick_o returns to 0; last_grant = grant; go IDLE.
REQ-020 Latency, timer free: db_level_o rises exactly CounterMax+4 edges after the first edge sampling sw_i high (edge 1 = sampling edge).
REQ-021 At most one db_tick_o bit high in any cycle; db_tick_o never high two consecutive cycles.
REQ-022 Non-granted channels wait; their requests are re-evaluated in the next IDLE cycle; a request that disappears while waiting is dropped silently.
REQ-023 busy_o = 1 in COUNT and COMMIT, 0 in IDLE; grant_o holds value while busy_o = 1.
REQ-024 Falling debounced edge updates db_level_o with identical timing; no pulse emitted.

Reset
REQ-025 rst_i high at a clock edge: state IDLE, counter 0, last_grant NumSw-1, synchronizer flops 0, db_level_o 0, db_tick_o 0, busy_o 0, grant_o 0.
REQ-026 Reset mid-COUNT discards the count with no pulse; reset wins over COMMIT in the same edge.

Structure
REQ-027 Package debounce_pkg holds the state enum (IDLE, COUNT, COMMIT) and a function computing CounterMax from ClkFreq and StableTime.
REQ-028 Sub-module sync_3ff (parameterized width) implements the synchronizer; the arbiter FSM and counter live in debounce_arbiter.

Verification
REQ-029 ClkFreq=1_000_000, StableTime=10 (CounterMax=10), NumSw=4 for all scenarios.
REQ-030 sw_i[0] 0->1 held -> db_level_o[0] high at edge 14, db_tick_o[0] high exactly that cycle, busy_o low at edge 15.
REQ-031 sw_i[1] high for 6 cycles then low -> no db_tick_o, db_level_o[1] stays 0, busy_o falls after abort.
REQ-032 sw_i[0] and sw_i[2] rise same edge -> channel 0 commits at edge 14, channel 2 granted next IDLE, commits 12 edges later; ticks never overlap.
REQ-033 All four channels held high repeatedly toggled -> grant order 0,1,2,3,0 (round-robin, no starvation).
REQ-034 rst_i asserted at edge 9 of scenario REQ-030 -> all outputs 0 next cycle; with sw_i held, db_level_o[0] rises 14 edges after rst_i deasserts.
